// File: rtl/dmem_arbiter.sv
// Arbitrates the single-ported data memory between the memory stage (D) and
// instruction fetch (F): one access in flight, D priority, F starvation guard.
module dmem_arbiter #(
  parameter int unsigned DEPTH      = 8192,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [63:0] d_rdata,
  output logic        d_err,
  input  logic        f_req,
  input  logic [63:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [63:0] f_rdata,
  output logic        f_err,
  output logic        m_en,
  output logic        m_we,
  output logic [12:0] m_addr,
  output logic [63:0] m_wdata,
  input  logic [63:0] m_rdata,
  output logic        busy
);

  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [3:0]    LAT_LOAD   = 4'(MEM_LAT - 1);
  localparam logic [63:0]   DEPTH64    = 64'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t        state, state_n;
  logic [SW-1:0] starve_cnt, starve_n;
  logic          win_f, win_f_n;
  logic          lat_we, we_n;
  logic          lat_err, err_n;
  logic [3:0]    wait_cnt, cnt_n;

  logic        d_gnt_n, d_rvalid_n, d_err_n;
  logic        f_gnt_n, f_rvalid_n, f_err_n;
  logic [63:0] d_rdata_n, f_rdata_n;
  logic        m_en_n, m_we_n;
  logic [12:0] m_addr_n;
  logic [63:0] m_wdata_n;
  logic        busy_n;

  logic        pick_f, pick_d;
  logic [63:0] sel_addr, sel_wdata;
  logic        sel_we, in_range;

  // Winner selection; only acted upon in IDLE.
  always_comb begin
    pick_f = 1'b0;
    pick_d = 1'b0;
    if (f_req && (starve_cnt == STARVE_TOP)) pick_f = 1'b1;
    else if (d_req)                          pick_d = 1'b1;
    else if (f_req)                          pick_f = 1'b1;
    sel_addr  = pick_f ? f_addr : d_addr;
    sel_we    = pick_d & d_we;
    sel_wdata = pick_d ? d_wdata : '0;
    in_range  = (sel_addr < DEPTH64);
  end

  // Next state and next value of every registered output; the memory strobe
  // is prepared in IDLE so that it appears registered during ACCESS.
  always_comb begin
    state_n    = state;
    starve_n   = starve_cnt;
    win_f_n    = win_f;
    we_n       = lat_we;
    err_n      = lat_err;
    cnt_n      = wait_cnt;
    d_gnt_n    = 1'b0;
    d_rvalid_n = 1'b0;
    d_err_n    = 1'b0;
    d_rdata_n  = '0;
    f_gnt_n    = 1'b0;
    f_rvalid_n = 1'b0;
    f_err_n    = 1'b0;
    f_rdata_n  = '0;
    m_en_n     = 1'b0;
    m_we_n     = 1'b0;
    m_addr_n   = '0;
    m_wdata_n  = '0;

    unique case (state)
      IDLE: begin
        if (pick_f || pick_d) begin
          state_n   = ACCESS;
          win_f_n   = pick_f;
          we_n      = sel_we;
          err_n     = ~in_range;
          d_gnt_n   = pick_d;
          f_gnt_n   = pick_f;
          m_en_n    = in_range;
          m_we_n    = in_range & sel_we;
          m_addr_n  = in_range ? sel_addr[12:0] : '0;
          m_wdata_n = in_range ? sel_wdata : '0;
          if (pick_f)
            starve_n = '0;
          else if (f_req && (starve_cnt != STARVE_TOP))
            starve_n = starve_cnt + 1'b1;
        end
      end
      ACCESS: begin
        if (lat_err || lat_we) begin
          state_n    = RESP;
          d_rvalid_n = ~win_f;
          f_rvalid_n = win_f;
          d_err_n    = ~win_f & lat_err;
          f_err_n    = win_f & lat_err;
        end else begin
          state_n = WAIT;
          cnt_n   = LAT_LOAD;
        end
      end
      WAIT: begin
        if (wait_cnt == '0) begin
          state_n    = RESP;
          d_rvalid_n = ~win_f;
          f_rvalid_n = win_f;
          d_rdata_n  = win_f ? '0 : m_rdata;
          f_rdata_n  = win_f ? m_rdata : '0;
        end else begin
          cnt_n = wait_cnt - 1'b1;
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      win_f      <= 1'b0;
      lat_we     <= 1'b0;
      lat_err    <= 1'b0;
      wait_cnt   <= '0;
      d_gnt      <= 1'b0;
      d_rvalid   <= 1'b0;
      d_err      <= 1'b0;
      d_rdata    <= '0;
      f_gnt      <= 1'b0;
      f_rvalid   <= 1'b0;
      f_err      <= 1'b0;
      f_rdata    <= '0;
      m_en       <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      starve_cnt <= starve_n;
      win_f      <= win_f_n;
      lat_we     <= we_n;
      lat_err    <= err_n;
      wait_cnt   <= cnt_n;
      d_gnt      <= d_gnt_n;
      d_rvalid   <= d_rvalid_n;
      d_err      <= d_err_n;
      d_rdata    <= d_rdata_n;
      f_gnt      <= f_gnt_n;
      f_rvalid   <= f_rvalid_n;
      f_err      <= f_err_n;
      f_rdata    <= f_rdata_n;
      m_en       <= m_en_n;
      m_we       <= m_we_n;
      m_addr     <= m_addr_n;
      m_wdata    <= m_wdata_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level reference model checked every cycle,
// a latency-accurate memory, directed literal checks and random traffic.
module tb_dmem_arbiter;

  localparam int unsigned DEPTH      = 8192;
  localparam int unsigned MEM_LAT    = 2;
  localparam int unsigned STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [63:0] d_addr = '0, d_wdata = '0;
  logic        d_gnt, d_rvalid, d_err;
  logic [63:0] d_rdata;
  logic        f_req = 1'b0;
  logic [63:0] f_addr = '0;
  logic        f_gnt, f_rvalid, f_err;
  logic [63:0] f_rdata;
  logic        m_en, m_we;
  logic [12:0] m_addr;
  logic [63:0] m_wdata;
  logic [63:0] m_rdata = '0;
  logic        busy;

  dmem_arbiter #(.DEPTH(DEPTH), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .f_req(f_req), .f_addr(f_addr),
    .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [63:0] init_val(input logic [12:0] a);
    return ({51'h0, a} * 64'h9E37_79B9_7F4A_7C15) ^ 64'hA5A5_0000_0000_5A5A;
  endfunction

  // Memory: reads return data MEM_LAT cycles after the strobe, garbage otherwise.
  logic [63:0] env_mem [int];
  logic [63:0] rd_at   [int];

  always @(negedge clk) begin
    if (rst_n && m_en) begin
      if (m_we) env_mem[int'(m_addr)] = m_wdata;
      else rd_at[cyc + int'(MEM_LAT)] = env_mem.exists(int'(m_addr)) ? env_mem[int'(m_addr)]
                                                                      : init_val(m_addr);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rd_at.exists(cyc)) begin
      m_rdata = rd_at[cyc];
      rd_at.delete(cyc);
    end else begin
      m_rdata = {$urandom, $urandom};
    end
  end

  // Reference model: each accepted request becomes a timeline of expected outputs.
  typedef struct packed {
    logic        busy;
    logic        d_gnt;
    logic        d_rvalid;
    logic        d_err;
    logic [63:0] d_rdata;
    logic        f_gnt;
    logic        f_rvalid;
    logic        f_err;
    logic [63:0] f_rdata;
    logic        m_en;
    logic        m_we;
    logic [12:0] m_addr;
    logic [63:0] m_wdata;
  } obs_t;

  obs_t        sched   [int];
  logic [63:0] ref_mem [int];
  int          free_at = 0;
  int          starve  = 0;

  function automatic logic [63:0] ref_read(input logic [12:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  always @(negedge clk) begin : model
    obs_t        e, g, t;
    bit          tf, td, w, ok;
    logic [63:0] a, wd;
    int          r;
    g.busy = busy;   g.d_gnt = d_gnt; g.d_rvalid = d_rvalid; g.d_err = d_err;
    g.d_rdata = d_rdata; g.f_gnt = f_gnt; g.f_rvalid = f_rvalid; g.f_err = f_err;
    g.f_rdata = f_rdata; g.m_en = m_en; g.m_we = m_we; g.m_addr = m_addr;
    g.m_wdata = m_wdata;
    if (!rst_n) begin
      e = '0;
      sched.delete();
      free_at = 0;
      starve  = 0;
    end else begin
      e = sched.exists(cyc) ? sched[cyc] : '0;
      sched.delete(cyc);
    end
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL cycle_outputs c=%0d got=%h expected=%h", cyc, g, e);
    end
    if (rst_n && cyc >= free_at) begin
      tf = f_req && (starve == int'(STARVE_MAX));
      td = !tf && d_req;
      tf = tf || (!td && f_req);
      if (tf || td) begin
        if (tf) starve = 0;
        else if (f_req && starve < int'(STARVE_MAX)) starve++;
        a  = tf ? f_addr : d_addr;
        w  = td && d_we;
        wd = td ? d_wdata : 64'h0;
        ok = (a < 64'(DEPTH));
        r  = (ok && !w) ? cyc + int'(MEM_LAT) + 2 : cyc + 2;
        for (int k = cyc + 1; k <= r; k++) begin
          t = sched.exists(k) ? sched[k] : '0;
          t.busy = 1'b1;
          sched[k] = t;
        end
        t = sched[cyc + 1];
        t.d_gnt   = td;
        t.f_gnt   = tf;
        t.m_en    = ok;
        t.m_we    = ok && w;
        t.m_addr  = ok ? a[12:0] : 13'h0;
        t.m_wdata = ok ? wd : 64'h0;
        sched[cyc + 1] = t;
        t = sched[r];
        t.d_rvalid = td;
        t.f_rvalid = tf;
        t.d_err    = td && !ok;
        t.f_err    = tf && !ok;
        t.d_rdata  = (td && ok && !w) ? ref_read(a[12:0]) : 64'h0;
        t.f_rdata  = (tf && ok) ? ref_read(a[12:0]) : 64'h0;
        sched[r] = t;
        if (ok && w) ref_mem[int'(a[12:0])] = wd;
        free_at = r + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    if (busy) chk("idle_timeout", 64'(busy), 64'h0);
  endtask

  // Holds both requests high and records the order of the first n grants (bit=1 means F).
  task automatic grant_seq(input int n, output logic [15:0] seq);
    int got = 0;
    int guard = 0;
    seq = '0;
    d_we = 1'b0; d_addr = 64'd20; f_addr = 64'd21;
    d_req = 1'b1; f_req = 1'b1;
    while (got < n && guard < 400) begin
      tick();
      guard++;
      if (d_gnt) got++;
      else if (f_gnt) begin
        seq[got] = 1'b1;
        got++;
      end
    end
    d_req = 1'b0; f_req = 1'b0;
    if (got < n) chk("grant_timeout", 64'(got), 64'(n));
  endtask

  function automatic logic [63:0] rand_addr();
    int unsigned s;
    s = $urandom_range(0, 15);
    if (s < 12)       return 64'($urandom_range(0, 31));
    else if (s == 12) return 64'd8191;
    else if (s == 13) return 64'd8192;
    else if (s == 14) return {32'hFFFF_FFFF, $urandom};
    else              return 64'($urandom_range(0, 8191));
  endfunction

  initial begin
    logic [15:0] seq;
    logic [63:0] oor [2];
    int fr, dg, k;

    env_mem[5] = 64'hDEAD;
    ref_mem[5] = 64'hDEAD;

    #1 rst_n = 1'b0;
    #1;
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_ctl", 64'({d_gnt, d_rvalid, d_err, f_gnt, f_rvalid, f_err, m_en, m_we}), 64'h0);
    chk("reset_data", d_rdata | f_rdata | m_wdata | 64'(m_addr), 64'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // D read of preloaded word
    wait_idle();
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'd5; d_wdata = 64'h0;
    tick();
    chk("rd_gnt_men", 64'({d_gnt, m_en, m_we}), 64'b110);
    chk("rd_maddr", 64'(m_addr), 64'd5);
    d_req = 1'b0;
    tick(); chk("rd_no_rvalid_c2", 64'(d_rvalid), 64'h0);
    tick(); chk("rd_no_rvalid_c3", 64'(d_rvalid), 64'h0);
    tick();
    chk("rd_rvalid_c4", 64'({d_rvalid, d_err}), 64'b10);
    chk("rd_data", d_rdata, 64'hDEAD);

    // D write then F read-back
    wait_idle();
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'd100; d_wdata = 64'h1234;
    tick();
    chk("wr_strobe", 64'({d_gnt, m_en, m_we}), 64'b111);
    chk("wr_maddr", 64'(m_addr), 64'd100);
    chk("wr_mwdata", m_wdata, 64'h1234);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    chk("wr_rvalid_c2", 64'({d_rvalid, d_err}), 64'b10);
    chk("wr_rdata_zero", d_rdata, 64'h0);
    wait_idle();
    f_req = 1'b1; f_addr = 64'd100;
    tick();
    chk("f_gnt", 64'(f_gnt), 64'h1);
    f_req = 1'b0;
    repeat (3) tick();
    chk("f_rvalid", 64'({f_rvalid, f_err}), 64'b10);
    chk("f_rdata", f_rdata, 64'h1234);

    // Continuous contention: D,D,D,D,F,D,D,D,D,F
    wait_idle();
    grant_seq(10, seq);
    chk("grant_order", 64'(seq), 64'h0210);

    // Out-of-range fetches
    oor[0] = 64'd8192;
    oor[1] = 64'hFFFF_FFFF_FFFF_0000;
    for (int i = 0; i < 2; i++) begin
      wait_idle();
      f_req = 1'b1; f_addr = oor[i];
      tick();
      chk("oor_gnt_no_men", 64'({f_gnt, m_en}), 64'b10);
      f_req = 1'b0;
      tick();
      chk("oor_resp_err", 64'({f_rvalid, f_err}), 64'b11);
      chk("oor_rdata_zero", f_rdata, 64'h0);
    end

    // D request raised while an F read is waiting on memory
    wait_idle();
    f_req = 1'b1; f_addr = 64'd3;
    tick();
    f_req = 1'b0;
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'd4;
    fr = -1; dg = -1; k = 2;
    while (dg < 0 && k < 20) begin
      tick();
      k++;
      if (f_rvalid) fr = k;
      if (d_gnt) begin
        dg = k;
        d_req = 1'b0;
      end
    end
    d_req = 1'b0;
    chk("f_resp_cycle", 64'(fr), 64'd4);
    chk("d_gnt_cycle", 64'(dg), 64'd6);

    // Reset in WAIT of a D read, with a nonzero starvation count beforehand
    wait_idle();
    grant_seq(2, seq);
    chk("pre_reset_order", 64'(seq), 64'h0);
    wait_idle();
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'd7;
    tick();
    d_req = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'h0);
    chk("midrst_ctl", 64'({d_gnt, d_rvalid, d_err, f_gnt, f_rvalid, f_err, m_en, m_we}), 64'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("no_rvalid_after_rst", 64'(d_rvalid), 64'h0);
    end
    grant_seq(5, seq);
    chk("post_reset_order", 64'(seq), 64'h0010);
    wait_idle();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (d_req) begin
        if (d_gnt) d_req = 1'b0;
        else if ($urandom_range(0, 99) < 3) d_req = 1'b0;
      end else if ($urandom_range(0, 99) < 35) begin
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = rand_addr();
        d_wdata = {$urandom, $urandom};
        d_req   = 1'b1;
      end
      if (f_req) begin
        if (f_gnt) f_req = 1'b0;
        else if ($urandom_range(0, 99) < 3) f_req = 1'b0;
      end else if ($urandom_range(0, 99) < 35) begin
        f_addr = rand_addr();
        f_req  = 1'b1;
      end
    end
    d_req = 1'b0;
    f_req = 1'b0;
    wait_idle();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
